// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU phase sequencer: FSM state encoding and the
// default instruction-cycle geometry used by the core top.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam int DEF_DIV      = 4;
    localparam int DEF_RF_PHASE = 1;

endpackage

// File: rtl/cpu_phase_ctrl_phase_counter.sv
// Modulo-DIV phase counter with enable, synchronous clear and terminal count.
// Clear has priority over enable.
module phase_counter #(
    parameter int DIV = 4,
    parameter int PW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] phase,
    output logic          tc
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    assign tc = (phase == LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= tc ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/cpu_phase_ctrl.sv
// Single-clock CPU phase sequencer: turns the system clock into one-cycle
// pipeline / register-file enables with run/halt, single-step and stall hold.
module cpu_phase_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int  DIV      = DEF_DIV,
    parameter int  RF_PHASE = DEF_RF_PHASE,
    localparam int PW       = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          step,
    input  logic          stall,
    output logic          ce_cpu,
    output logic          ce_rf,
    output logic [PW-1:0] phase,
    output logic          halted,
    output logic [31:0]   cycle_cnt
);

    state_t state;
    state_t state_nxt;
    logic   step_q;
    logic   step_rise;
    logic   active;
    logic   tc;

    assign active    = (state != ST_HALT) && !stall && !rst;
    assign step_rise = step && !step_q;
    assign ce_cpu    = active && tc;
    assign ce_rf     = active && (phase == PW'(RF_PHASE));
    assign halted    = (state == ST_HALT);

    // Phase is parked at 0 whenever halted so the first running cycle is phase 0.
    phase_counter #(
        .DIV (DIV),
        .PW  (PW)
    ) u_phase (
        .clk   (clk),
        .clr   (rst || (state == ST_HALT)),
        .en    (active),
        .phase (phase),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HALT;
            step_q    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state  <= state_nxt;
            step_q <= step;
            if (ce_cpu) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

    // Leaving RUN/STEP only happens on ce_cpu, so an instruction cycle always completes.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALT: begin
                if (run) begin
                    state_nxt = ST_RUN;
                end else if (step_rise) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (ce_cpu && !run) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_STEP: begin
                if (ce_cpu) begin
                    state_nxt = run ? ST_RUN : ST_HALT;
                end
            end
            default: state_nxt = ST_HALT;
        endcase
    end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Randomized and directed checks of cpu_phase_ctrl (DIV=4 and DIV=2 builds)
// against an instruction-cycle-level reference model.
module tb_cpu_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, step, stall;
    logic        a_ce_cpu, a_ce_rf, a_halted;
    logic [1:0]  a_phase;
    logic [31:0] a_cycle_cnt;
    logic        b_ce_cpu, b_ce_rf, b_halted;
    logic [0:0]  b_phase;
    logic [31:0] b_cycle_cnt;

    cpu_phase_ctrl #(.DIV(4), .RF_PHASE(1)) dut_a (
        .clk(clk), .rst(rst), .run(run), .step(step), .stall(stall),
        .ce_cpu(a_ce_cpu), .ce_rf(a_ce_rf), .phase(a_phase),
        .halted(a_halted), .cycle_cnt(a_cycle_cnt)
    );

    cpu_phase_ctrl #(.DIV(2), .RF_PHASE(1)) dut_b (
        .clk(clk), .rst(rst), .run(run), .step(step), .stall(stall),
        .ce_cpu(b_ce_cpu), .ce_rf(b_ce_rf), .phase(b_phase),
        .halted(b_halted), .cycle_cnt(b_cycle_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: "busy" means an instruction cycle is in progress; pos is the
    // position inside it; a finished cycle continues only if run is high.
    int          div_m [2] = '{4, 2};
    int          rfp_m [2] = '{1, 1};
    bit          busy  [2];
    int          pos   [2];
    int unsigned cnt   [2];
    bit          prev_step;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            busy[b] = 1'b0;
            pos[b]  = 0;
            cnt[b]  = 0;
        end
        prev_step = 1'b0;
    endtask

    task automatic check_outputs();
        for (int b = 0; b < 2; b++) begin
            bit          act, e_cpu, e_rf;
            logic [31:0] g_cpu, g_rf, g_ph, g_h, g_cnt;
            act   = busy[b] && !stall && !rst;
            e_cpu = act && (pos[b] == div_m[b] - 1);
            e_rf  = act && (pos[b] == rfp_m[b]);
            if (b == 0) begin
                g_cpu = 32'(a_ce_cpu); g_rf = 32'(a_ce_rf); g_ph = 32'(a_phase);
                g_h   = 32'(a_halted); g_cnt = a_cycle_cnt;
            end else begin
                g_cpu = 32'(b_ce_cpu); g_rf = 32'(b_ce_rf); g_ph = 32'(b_phase);
                g_h   = 32'(b_halted); g_cnt = b_cycle_cnt;
            end
            check_eq($sformatf("ce_cpu[%0d]", b), g_cpu, 32'(e_cpu));
            check_eq($sformatf("ce_rf[%0d]", b), g_rf, 32'(e_rf));
            check_eq($sformatf("phase[%0d]", b), g_ph, 32'(pos[b]));
            check_eq($sformatf("halted[%0d]", b), g_h, 32'(!busy[b]));
            check_eq($sformatf("cycle_cnt[%0d]", b), g_cnt, cnt[b]);
        end
    endtask

    task automatic model_advance();
        for (int b = 0; b < 2; b++) begin
            if (rst) begin
                busy[b] = 1'b0;
                pos[b]  = 0;
                cnt[b]  = 0;
            end else if (!busy[b]) begin
                busy[b] = run || (step && !prev_step);
                pos[b]  = 0;
            end else if (!stall) begin
                if (pos[b] == div_m[b] - 1) begin
                    pos[b]  = 0;
                    cnt[b]  = cnt[b] + 1;
                    busy[b] = run;
                end else begin
                    pos[b] = pos[b] + 1;
                end
            end
        end
        prev_step = rst ? 1'b0 : step;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (!(busy[0] && pos[0] == p) && n < 40) begin
            tick();
            n++;
        end
        check_eq("wait_phase_bound", 32'(n < 40), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1]) && n < 40) begin
            tick();
            n++;
        end
        check_eq("wait_idle_bound", 32'(n < 40), 32'd1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; step = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // reset held with run high and step toggling
        for (int i = 0; i < 3; i++) begin
            step = ~step;
            tick();
        end

        // free run for 41 cycles
        rst = 1'b0; step = 1'b0; run = 1'b1;
        for (int i = 0; i < 41; i++) tick();
        check_eq("freerun_cnt_div4", a_cycle_cnt, 32'd10);
        check_eq("freerun_halted_div4", 32'(a_halted), 32'd0);

        // stall for 3 cycles at phase 2
        wait_pos(2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // single step: hold step high, then a second edge
        run = 1'b0;
        wait_idle();
        step = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        step = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        step = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        step = 1'b0;
        tick();

        // run dropped mid-cycle at phase 1
        run = 1'b1;
        wait_pos(1);
        run = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // reset mid-run at phase 2
        run = 1'b1;
        wait_pos(2);
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            run   = ($urandom_range(0, 9) < 6);
            step  = $urandom_range(0, 1) == 1;
            stall = ($urandom_range(0, 9) < 2);
            rst   = ($urandom_range(0, 99) < 2);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
